// File: rtl/cpu_pkg.sv
// Shared types for the 6502-style CPU core: addressing modes, address-sequencer
// states and the per-mode operand byte count.
package cpu_pkg;

  typedef enum logic [2:0] {
    ZP      = 3'd0,
    ZP_IDX  = 3'd1,
    ABS     = 3'd2,
    ABS_IDX = 3'd3,
    IND_X   = 3'd4,
    IND_Y   = 3'd5,
    IND     = 3'd6,
    RSV     = 3'd7
  } adr_mode_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    OP_LO    = 3'd1,
    OP_HI    = 3'd2,
    PTR_CALC = 3'd3,
    PTR_LO   = 3'd4,
    PTR_HI   = 3'd5,
    FIX      = 3'd6,
    DONE     = 3'd7
  } addr_seq_state_t;

  // Operand bytes following the opcode; the reserved mode is treated as one byte.
  function automatic logic [1:0] op_count(input adr_mode_t m);
    case (m)
      ABS, ABS_IDX, IND: op_count = 2'd2;
      default:           op_count = 2'd1;
    endcase
  endfunction

  function automatic logic is_ptr_mode(input adr_mode_t m);
    is_ptr_mode = (m == IND_X) || (m == IND_Y) || (m == IND);
  endfunction

endpackage

// File: rtl/cpu_addr_add.sv
// Combinational {hi,lo}+index adder with carry into the high byte, or a
// zero-page-wrapped low-byte sum when zp_wrap is set.
module cpu_addr_add #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] index,
  input  logic              zp_wrap,
  output logic [ADDR_W-1:0] sum,
  output logic              carry
);

  logic [DATA_W:0] lo_sum;

  // NOTE: every output of a combinational block gets a value on every path
  // (defaults first); otherwise synthesis infers a latch.
  always_comb begin
    lo_sum = {1'b0, lo} + {1'b0, index};
    sum    = {{DATA_W{1'b0}}, lo_sum[DATA_W-1:0]};
    carry  = 1'b0;
    if (!zp_wrap) begin
      sum   = {hi + DATA_W'(lo_sum[DATA_W]), lo_sum[DATA_W-1:0]};
      carry = lo_sum[DATA_W];
    end
  end

endmodule

// File: rtl/cpu_addr_seq.sv
// Effective-address sequencer: fetches operand and pointer bytes over a
// registered read port and reports ea, pc_next and page_cross with a pulse.
module cpu_addr_seq
  import cpu_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 16,
  parameter int PAGE_PENALTY = 1,
  parameter int NMOS_JMP_BUG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] index,
  input  logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_adr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ea_valid,
  output logic [ADDR_W-1:0] ea,
  output logic [ADDR_W-1:0] pc_next,
  output logic              page_cross
);

  if (ADDR_W != 2 * DATA_W) begin : g_width_check
    $error("cpu_addr_seq: ADDR_W (%0d) must equal 2*DATA_W (%0d)", ADDR_W, 2 * DATA_W);
  end

  addr_seq_state_t   state;
  adr_mode_t         mode_r;
  adr_mode_t         mode_in;
  logic [DATA_W-1:0] index_r;
  logic [DATA_W-1:0] opnd_lo;
  logic [DATA_W-1:0] ptr_lo_data;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W-1:0] ptr_inc;
  logic              ptr_phase;
  logic              two_byte;

  logic [DATA_W-1:0] add_hi;
  logic [DATA_W-1:0] add_lo;
  logic [DATA_W-1:0] add_idx;
  logic              add_zp;
  logic [ADDR_W-1:0] add_sum;
  logic              add_carry;

  assign mode_in  = adr_mode_t'(mode);
  assign two_byte = (op_count(mode_r) == 2'd2);
  assign busy     = (state != IDLE);

  // The adder always sees the byte arriving this cycle; ptr_phase tells
  // whether that byte closes the operand or the pointer fetch.
  always_comb begin
    add_hi  = '0;
    add_lo  = mem_rdata;
    add_idx = '0;
    add_zp  = 1'b1;
    if (ptr_phase) begin
      add_hi = mem_rdata;
      add_lo = ptr_lo_data;
      add_zp = 1'b0;
      if (mode_r == IND_Y) add_idx = index_r;
    end else if (two_byte) begin
      add_hi = mem_rdata;
      add_lo = opnd_lo;
      add_zp = 1'b0;
      if (mode_r == ABS_IDX) add_idx = index_r;
    end else if (mode_r == ZP_IDX || mode_r == IND_X) begin
      add_idx = index_r;
    end
  end

  cpu_addr_add #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_add (
    .hi     (add_hi),
    .lo     (add_lo),
    .index  (add_idx),
    .zp_wrap(add_zp),
    .sum    (add_sum),
    .carry  (add_carry)
  );

  // Second pointer byte: zero-page pointers wrap in page zero; the NMOS JMP
  // quirk wraps within the pointer's own page instead of carrying.
  always_comb begin
    ptr_inc = {{DATA_W{1'b0}}, ptr_r[DATA_W-1:0] + DATA_W'(1)};
    if (mode_r == IND) begin
      if (NMOS_JMP_BUG != 0) ptr_inc = {ptr_r[ADDR_W-1:DATA_W], ptr_r[DATA_W-1:0] + DATA_W'(1)};
      else                   ptr_inc = ptr_r + ADDR_W'(1);
    end
  end

  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mode_r      <= ZP;
      index_r     <= '0;
      pc_r        <= '0;
      opnd_lo     <= '0;
      ptr_lo_data <= '0;
      ptr_r       <= '0;
      ptr_phase   <= 1'b0;
      mem_rd      <= 1'b0;
      mem_adr     <= '0;
      ea_valid    <= 1'b0;
      ea          <= '0;
      pc_next     <= '0;
      page_cross  <= 1'b0;
    end else begin
      mem_rd   <= 1'b0;
      ea_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_r     <= mode_in;
            index_r    <= index;
            pc_r       <= pc;
            ptr_phase  <= 1'b0;
            page_cross <= 1'b0;
            pc_next    <= pc + ADDR_W'(op_count(mode_in));
            if (mode_in == RSV) begin
              ea       <= '0;
              ea_valid <= 1'b1;
              state    <= DONE;
            end else begin
              mem_rd  <= 1'b1;
              mem_adr <= pc;
              state   <= OP_LO;
            end
          end
        end
        OP_LO: begin
          if (two_byte) begin
            mem_rd  <= 1'b1;
            mem_adr <= pc_r + ADDR_W'(1);
            state   <= OP_HI;
          end else begin
            state <= PTR_CALC;
          end
        end
        OP_HI: begin
          opnd_lo <= mem_rdata;
          state   <= PTR_CALC;
        end
        PTR_CALC: begin
          if (!ptr_phase && is_ptr_mode(mode_r)) begin
            ptr_r     <= add_sum;
            mem_rd    <= 1'b1;
            mem_adr   <= add_sum;
            ptr_phase <= 1'b1;
            state     <= PTR_LO;
          end else begin
            ea         <= add_sum;
            page_cross <= add_carry;
            if (add_carry && PAGE_PENALTY != 0) begin
              state <= FIX;
            end else begin
              ea_valid <= 1'b1;
              state    <= DONE;
            end
          end
        end
        PTR_LO: begin
          mem_rd  <= 1'b1;
          mem_adr <= ptr_inc;
          state   <= PTR_HI;
        end
        PTR_HI: begin
          ptr_lo_data <= mem_rdata;
          state       <= PTR_CALC;
        end
        FIX: begin
          ea_valid <= 1'b1;
          state    <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
